// File: rtl/glitch_monitor.sv
// glitch_monitor: receiver for the ring-oscillator glitch sensor.
// Synchronizes the free-running sensor output and counts its rising edges
// over fixed windows of WINDOW clocks. Each window whose count falls outside
// LO_BOUND..HI_BOUND is a strike. STRIKES consecutive strikes raise `alarm`.
//
// Build option GLITCH_MON_STICKY_EN:
//   defined   - alarm latches; only clr, rst or en=0 clear it.
//   undefined - clr is ignored; the first clean window drops the alarm.
module glitch_monitor #(
    parameter int WINDOW   = 256,
    parameter int CNT_W    = 9,
    parameter int LO_BOUND = 20,
    parameter int HI_BOUND = 120,
    parameter int STRIKES  = 2,
    parameter int WARMUP   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             ro_in,
    input  logic             clr,
    output logic             count_valid,
    output logic [CNT_W-1:0] last_count,
    output logic             violation,
    output logic             alarm
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int STR_W  = $clog2(STRIKES + 1);
    localparam int WARM_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    localparam logic [CNT_W-1:0] LO_B     = CNT_W'(LO_BOUND);
    localparam logic [CNT_W-1:0] HI_B     = CNT_W'(HI_BOUND);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
    localparam logic [STR_W-1:0] STR_MAX  = STR_W'(STRIKES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WARM  = 2'd1,
        S_RUN   = 2'd2,
        S_ALARM = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               sync3_q, sync3_d;
    logic [WIN_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
    logic [WARM_W-1:0]  warm_cnt_q, warm_cnt_d;
    logic [STR_W-1:0]   strike_q, strike_d;
    logic               count_valid_q, count_valid_d;
    logic [CNT_W-1:0]   last_count_q, last_count_d;
    logic               violation_q, violation_d;
    logic               alarm_q, alarm_d;

    logic               edge_det;
    logic               terminal;
    logic [CNT_W-1:0]   cnt_final;
    logic               out_of_band;
    logic [STR_W-1:0]   strike_inc;
    logic               raise;

`ifndef GLITCH_MON_STICKY_EN
    // clr has no function when the alarm is self-clearing.
    logic unused_clr;
    assign unused_clr = clr;
`endif

    // Next-state computation for the synchronizer, counters, FSM and outputs.
    always_comb begin
        sync1_d       = ro_in;
        sync2_d       = sync1_q;
        sync3_d       = sync2_q;

        edge_det      = sync2_q & ~sync3_q;
        terminal      = (win_q == WIN_LAST);
        // Count including an edge that lands on the current cycle, saturating.
        cnt_final     = (edge_det && !(&edge_cnt_q)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        out_of_band   = (cnt_final < LO_B) || (cnt_final > HI_B);
        strike_inc    = (strike_q == STR_MAX) ? strike_q : strike_q + 1'b1;
        raise         = out_of_band && (strike_inc == STR_MAX);

        state_d       = state_q;
        win_d         = win_q;
        edge_cnt_d    = edge_cnt_q;
        warm_cnt_d    = warm_cnt_q;
        strike_d      = strike_q;
        count_valid_d = 1'b0;
        last_count_d  = last_count_q;
        violation_d   = 1'b0;
        alarm_d       = alarm_q;

        if (!en) begin
            // Disabling discards any partial window and clears the alarm.
            state_d    = S_IDLE;
            win_d      = '0;
            edge_cnt_d = '0;
            warm_cnt_d = '0;
            strike_d   = '0;
            alarm_d    = 1'b0;
        end else if (state_q == S_IDLE) begin
            state_d = (WARMUP == 0) ? S_RUN : S_WARM;
        end else begin
            // Measurement runs back-to-back in every active state.
            if (terminal) begin
                win_d         = '0;
                edge_cnt_d    = '0;
                count_valid_d = 1'b1;
                last_count_d  = cnt_final;
            end else begin
                win_d      = win_q + 1'b1;
                edge_cnt_d = cnt_final;
            end

            if (state_q == S_WARM) begin
                if (terminal) begin
                    if (int'(warm_cnt_q) + 1 >= WARMUP) begin
                        state_d    = S_RUN;
                        warm_cnt_d = '0;
                    end else begin
                        warm_cnt_d = warm_cnt_q + 1'b1;
                    end
                end
            end else if (terminal) begin
                violation_d = out_of_band;
                if (out_of_band) begin
                    strike_d = strike_inc;
                    if (raise) begin
                        state_d = S_ALARM;
                        alarm_d = 1'b1;
                    end
                end else begin
                    strike_d = '0;
`ifndef GLITCH_MON_STICKY_EN
                    if (state_q == S_ALARM) begin
                        state_d = S_RUN;
                        alarm_d = 1'b0;
                    end
`endif
                end
            end

`ifdef GLITCH_MON_STICKY_EN
            // A window that raises the alarm in the same cycle beats clr.
            if ((state_q == S_ALARM) && clr && !(terminal && raise)) begin
                state_d  = S_RUN;
                alarm_d  = 1'b0;
                strike_d = '0;
            end
`endif
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            sync3_q       <= 1'b0;
            win_q         <= '0;
            edge_cnt_q    <= '0;
            warm_cnt_q    <= '0;
            strike_q      <= '0;
            count_valid_q <= 1'b0;
            last_count_q  <= '0;
            violation_q   <= 1'b0;
            alarm_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            sync3_q       <= sync3_d;
            win_q         <= win_d;
            edge_cnt_q    <= edge_cnt_d;
            warm_cnt_q    <= warm_cnt_d;
            strike_q      <= strike_d;
            count_valid_q <= count_valid_d;
            last_count_q  <= last_count_d;
            violation_q   <= violation_d;
            alarm_q       <= alarm_d;
        end
    end

    assign count_valid = count_valid_q;
    assign last_count  = last_count_q;
    assign violation   = violation_q;
    assign alarm       = alarm_q;

endmodule

// File: doc/glitch_monitor.md
# glitch_monitor

Clock-domain receiver for the ring-oscillator glitch sensor output. Samples the free-running sensor signal, counts its rising edges over a fixed window of system clocks, and flags any window whose count falls outside a programmed band. After a run of consecutive bad windows it raises an alarm that the reset and tamper logic consumes. A stalled sensor and an abnormally fast sensor are both treated as glitch evidence.

## Interface
Parameters:
- `WINDOW`, 256: measurement window length in clk cycles (≥ 4).
- `CNT_W`, 9: edge-counter width; the counter saturates at 2^CNT_W−1.
- `LO_BOUND`, 20: minimum legal edge count per window.
- `HI_BOUND`, 120: maximum legal edge count per window.
- `STRIKES`, 2: number of consecutive violating windows that raises the alarm (≥ 1).
- `WARMUP`, 2: number of windows after enable that are measured but not evaluated.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `en` in 1: monitor enable. Level-sensitive.
- `ro_in` in 1: asynchronous sensor output.
- `clr` in 1: one-cycle alarm clear. Only meaningful with the sticky option.
- `count_valid` out 1: one-cycle pulse when `last_count` updates.
- `last_count` out CNT_W: edge count of the most recently completed window.
- `violation` out 1: one-cycle pulse, coincident with `count_valid`, when that window is out of band.
- `alarm` out 1: glitch alarm level.

## Operation
- Input path: `ro_in` passes through a 2-flop synchronizer, then a rising-edge detector on the second-stage flop against a third flop.
- Edge count: increments once per detected edge and saturates at all-ones.
- Window counter: runs 0..WINDOW−1. On the terminal cycle, the edge count plus any edge in that cycle is latched, and the edge counter restarts at 0 with no gap between windows.
- FSM states:
  - IDLE: counters held at 0. Go to WARM when `en`=1.
  - WARM: counts windows. After WARMUP completed windows, go to RUN. If WARMUP=0, go directly to RUN.
  - RUN: evaluates every window.
  - ALARM: keeps measuring and evaluating.
- `en`=0 in any state returns the FSM to IDLE next cycle and clears the window, edge and strike counters. `alarm` is handled per Configuration.
- Evaluation (RUN/ALARM only): a window violates when `count < LO_BOUND` or `count > HI_BOUND`.
  - A violating window increments the strike counter, which saturates at STRIKES.
  - A clean window clears the strike counter.
  - When the strike counter reaches STRIKES, the FSM enters ALARM and `alarm` rises.
- WARM windows still update `last_count` and pulse `count_valid`. `violation` is forced to 0 for them.
- Bounds are compared as unsigned CNT_W-bit values. HI_BOUND must be < 2^CNT_W−1, so a saturated count always violates.
- Supported input rate: edge spacing ≥ 4 clk cycles. Faster inputs alias, and the resulting counts are only guaranteed to be ≤ the true count.

## Timing
- Reset values: `count_valid`=0, `last_count`=0, `violation`=0, `alarm`=0, FSM in IDLE, all counters 0.
- Latency from an `ro_in` rising edge to the edge-counter increment: 3 clk.
- `count_valid`, `last_count`, `violation` and the `alarm` rise all take effect on the cycle after the window terminal cycle.
- `clr` and a new alarm-raising window in the same cycle: the raise wins and `alarm` stays 1.
- `rst` mid-window: all state returns to reset values next cycle. The partial window is discarded.
- `en` falling mid-window: the partial window is discarded. No `count_valid` is produced.

## Configuration
- `GLITCH_MON_STICKY_EN` defined:
  - `alarm` latches once raised and clears only on `clr`, `rst`, or `en`=0.
  - ALARM is exited to RUN only by `clr`, with the strike counter cleared.
- Not defined:
  - `clr` is ignored.
  - The first clean window in ALARM drops `alarm` and returns the FSM to RUN, with strikes cleared.
  - `en`=0 also clears `alarm`.

## Test plan
Defaults: WINDOW=256, bounds 20..120, STRIKES=2, WARMUP=2.
- `ro_in` period 8 clk (32 edges/window): `last_count`=32 every window, `violation`=0, `alarm` stays 0.
- `ro_in` held 0 after enable: 2 warmup windows with no violation, then `violation` pulses on windows 3 and 4. `alarm` rises 1 cycle after the end of window 4, i.e. 4·256+1 cycles after `en`.
- `ro_in` period 4 for one window (64 edges), then stuck-high for one window, then period 4 again: a single `violation` pulse, strikes reset, `alarm` stays 0.
- Two consecutive windows of period 2 (128 edges before aliasing; recorded count as sampled) with `HI_BOUND` lowered to 50: `alarm`=1.
  - With sticky: `alarm` holds through clean windows until a `clr` pulse, then reads 0.
  - Without sticky: `alarm` drops after the first clean window.
- `rst` asserted at cycle 100 of a window while in ALARM: all outputs are 0 next cycle, and the FSM restarts in WARM once `en` is seen.
- `clr` pulsed on the same cycle that a second violation raises `alarm`: `alarm`=1 afterward.
